// File: rtl/keccak_pkg.sv
// Shared Keccak squeeze constants and the squeeze FSM state encoding.
// Holds DATA_SIZE, RATE, WORDS_PER_BLOCK and sq_state_t.
package keccak_pkg;

    localparam int DATA_SIZE       = 64;
    localparam int RATE            = 1344;
    localparam int WORDS_PER_BLOCK = RATE / DATA_SIZE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } sq_state_t;

endpackage

// File: rtl/piso_squeeze.sv
// Parallel-in serial-out squeeze: emits the rate part of a permuted
// Keccak state as DATA_SIZE-bit words, least-significant lane first.
// Ports: clk, hash_init (sync active-high reset), block_in/load_en
// (block capture), data_out/out_valid/out_ready (word handshake),
// block_done (block exhausted pulse), busy (not IDLE).
// Optional macro SQUEEZE_LIMIT_EN adds out_len/out_last and stops the
// squeeze after out_len words in total (DONE state).
module piso_squeeze #(
    parameter int DATA_SIZE = keccak_pkg::DATA_SIZE,
    parameter int RATE      = keccak_pkg::RATE
) (
    input  logic                 clk,
    input  logic                 hash_init,
    input  logic [RATE-1:0]      block_in,
    input  logic                 load_en,
`ifdef SQUEEZE_LIMIT_EN
    input  logic [15:0]          out_len,
    output logic                 out_last,
`endif
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 block_done,
    output logic                 busy
);

    import keccak_pkg::*;

    localparam int         WORDS    = RATE / DATA_SIZE;
    localparam logic [4:0] LAST_IDX = 5'(WORDS - 1);

    sq_state_t       state;
    logic [RATE-1:0] sreg;
    logic [4:0]      cnt;
    logic            bd_q;
    logic            last_word;

`ifdef SQUEEZE_LIMIT_EN
    logic [15:0] rem;
    logic        first_load;
`endif

    assign last_word  = (cnt == LAST_IDX);
    assign data_out   = sreg[DATA_SIZE-1:0];
    assign out_valid  = (state == SEND);
    assign busy       = (state != IDLE);
    assign block_done = bd_q;

`ifdef SQUEEZE_LIMIT_EN
    assign out_last = (state == SEND) && (rem == 16'd1);
`endif

    always_ff @(posedge clk) begin
        if (hash_init) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
            bd_q  <= 1'b0;
`ifdef SQUEEZE_LIMIT_EN
            rem        <= '0;
            first_load <= 1'b1;
`endif
        end else begin
            bd_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (load_en) begin
                        sreg  <= block_in;
                        cnt   <= '0;
                        state <= SEND;
`ifdef SQUEEZE_LIMIT_EN
                        // Length is only taken from the first block;
                        // later blocks continue the running count.
                        if (first_load) begin
                            first_load <= 1'b0;
                            rem        <= out_len;
                            if (out_len == 16'd0)
                                state <= DONE;
                        end
`endif
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        sreg <= sreg >> DATA_SIZE;
                        // Counter saturates on the last word.
                        if (!last_word)
                            cnt <= cnt + 5'd1;
`ifdef SQUEEZE_LIMIT_EN
                        rem <= rem - 16'd1;
                        if (rem == 16'd1) begin
                            state <= DONE;
                        end else if (last_word) begin
                            state <= IDLE;
                            bd_q  <= 1'b1;
                        end
`else
                        if (last_word) begin
                            state <= IDLE;
                            bd_q  <= 1'b1;
                        end
`endif
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_squeeze.sv
// Self-checking bench for piso_squeeze: scoreboard of expected words,
// stall hold checks, block_done timing, reset and limit behaviour.
module tb_piso_squeeze;

    import keccak_pkg::*;

    localparam int DW = DATA_SIZE;
    localparam int RW = RATE;
    localparam int NW = WORDS_PER_BLOCK;

    typedef struct {
        logic [DW-1:0] w;
        logic          last;
    } exp_t;

    logic          clk       = 1'b0;
    logic          hash_init = 1'b1;
    logic          load_en   = 1'b0;
    logic          out_ready = 1'b0;
    logic [RW-1:0] block_in  = '0;
    logic [DW-1:0] data_out;
    logic          out_valid;
    logic          block_done;
    logic          busy;
`ifdef SQUEEZE_LIMIT_EN
    logic [15:0]   out_len   = 16'd100;
    logic          out_last;
`endif

    exp_t          sb[$];
    exp_t          mon_e;
    int            n_chk  = 0;
    int            n_fail = 0;
    int            xfers  = 0;
    int            bd_cnt = 0;
    logic          stall_q = 1'b0;
    logic [DW-1:0] held = '0;
    bit            toggle_mode = 1'b0;
    int            ph = 0;
    int            rem_m = 0;
    bit            first_m = 1'b1;

    piso_squeeze dut (
        .clk        (clk),
        .hash_init  (hash_init),
        .block_in   (block_in),
        .load_en    (load_en),
`ifdef SQUEEZE_LIMIT_EN
        .out_len    (out_len),
        .out_last   (out_last),
`endif
        .data_out   (data_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .block_done (block_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: sample away from the active edge.
    always @(negedge clk) begin
        if (!hash_init) begin
            if (block_done) bd_cnt++;
            if (stall_q) check("stall_hold", 64'(data_out), 64'(held));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_word", 64'(out_valid), 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("word", 64'(data_out), 64'(mon_e.w));
`ifdef SQUEEZE_LIMIT_EN
                    check("last", 64'(out_last), 64'(mon_e.last));
`endif
                end
                xfers++;
            end
            stall_q = out_valid && !out_ready;
            held    = data_out;
        end else begin
            stall_q = 1'b0;
        end
    end

    // Ready pattern 1,0,0 repeating when enabled.
    initial forever begin
        @(posedge clk);
        #1;
        if (toggle_mode) begin
            out_ready = (ph == 0);
            ph = (ph + 1) % 3;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [RW-1:0] mk_block(input int base);
        logic [RW-1:0] b;
        b = '0;
        for (int i = 0; i < NW; i++)
            b[i*DW +: DW] = DW'(base + i + 1);
        return b;
    endfunction

    task automatic do_reset();
        hash_init = 1'b1;
        tick();
        tick();
        hash_init = 1'b0;
        first_m = 1'b1;
        sb.delete();
    endtask

    task automatic load(input int base);
        block_in = mk_block(base);
        load_en  = 1'b1;
`ifdef SQUEEZE_LIMIT_EN
        if (first_m) rem_m = int'(out_len);
`endif
        first_m = 1'b0;
        tick();
        load_en = 1'b0;
    endtask

    task automatic push_block(input int base);
        exp_t e;
        for (int i = 0; i < NW; i++) begin
            e.w = DW'(base + i + 1);
            e.last = 1'b0;
`ifdef SQUEEZE_LIMIT_EN
            if (rem_m == 0) break;
            e.last = (rem_m == 1);
            rem_m--;
`endif
            sb.push_back(e);
        end
    endtask

    task automatic wait_drain(input int budget, output int k);
        k = 0;
        while (sb.size() != 0 && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("drain", 64'(sb.size()), 64'd0);
    endtask

    task automatic wait_xfers(input int target);
        int k;
        k = 0;
        while (xfers < target && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("reach_word", 64'(xfers), 64'(target));
    endtask

    // Called right after the final word was popped, before its edge.
    task automatic check_block_end();
        @(negedge clk);
        check("block_done_pulse", 64'(block_done), 64'd1);
        check("idle_after_block", 64'(busy), 64'd0);
        check("valid_in_idle", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("block_done_width", 64'(block_done), 64'd0);
    endtask

    initial begin
        int k;
        int x0;

        // Reset state
        tick();
        tick();
        check("rst_data", 64'(data_out), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_bd", 64'(block_done), 64'd0);
`ifdef SQUEEZE_LIMIT_EN
        check("rst_last", 64'(out_last), 64'd0);
        out_len = 16'd100;
`endif
        do_reset();

        // Straight block, ready held high
        out_ready = 1'b1;
        load(0);
        check("busy_send", 64'(busy), 64'd1);
        push_block(0);
        wait_drain(60, k);
        check("consecutive", 64'(k), 64'(NW));
        check_block_end();
        check("bd_count_1", 64'(bd_cnt), 64'd1);

        // Ready toggling 1,0,0
        tick();
        ph = 0;
        toggle_mode = 1'b1;
        load(0);
        push_block(0);
        wait_drain(200, k);
        check_block_end();
        toggle_mode = 1'b0;
        out_ready = 1'b1;
        check("bd_count_2", 64'(bd_cnt), 64'd2);

        // load_en during SEND at word 10 is ignored
        tick();
        out_ready = 1'b1;
        x0 = xfers;
        load(20);
        push_block(20);
        wait_xfers(x0 + 10);
        tick();
        block_in = mk_block(500);
        load_en = 1'b1;
        tick();
        load_en = 1'b0;
        wait_drain(60, k);
        check_block_end();
        check("bd_count_3", 64'(bd_cnt), 64'd3);

        // hash_init after word 7 overrides transfer and load
        tick();
        x0 = xfers;
        load(30);
        push_block(30);
        wait_xfers(x0 + 7);
        tick();
        hash_init = 1'b1;
        load_en = 1'b1;
        tick();
        hash_init = 1'b0;
        load_en = 1'b0;
        first_m = 1'b1;
        sb.delete();
        @(negedge clk);
        check("init_valid", 64'(out_valid), 64'd0);
        check("init_busy", 64'(busy), 64'd0);
        check("init_data", 64'(data_out), 64'd0);
        check("init_bd", 64'(block_done), 64'd0);
        tick();
        load(40);
        push_block(40);
        wait_drain(60, k);
        check("restart_len", 64'(k), 64'(NW));
        check_block_end();
        check("bd_count_4", 64'(bd_cnt), 64'd4);

`ifdef SQUEEZE_LIMIT_EN
        // Four-word squeeze ends in DONE
        tick();
        out_len = 16'd4;
        do_reset();
        x0 = bd_cnt;
        load(50);
        push_block(50);
        wait_drain(30, k);
        @(negedge clk);
        check("done_busy", 64'(busy), 64'd1);
        check("done_valid", 64'(out_valid), 64'd0);
        check("done_last", 64'(out_last), 64'd0);
        tick();
        load(600);
        repeat (3) @(negedge clk);
        check("done_hold_busy", 64'(busy), 64'd1);
        check("done_hold_valid", 64'(out_valid), 64'd0);
        check("done_no_bd", 64'(bd_cnt), 64'(x0));

        // 25 words across two blocks
        tick();
        out_len = 16'd25;
        do_reset();
        load(60);
        push_block(60);
        wait_drain(60, k);
        check_block_end();
        tick();
        out_len = 16'd3;
        load(70);
        push_block(70);
        wait_drain(30, k);
        @(negedge clk);
        check("len25_done", 64'(busy), 64'd1);
        check("len25_valid", 64'(out_valid), 64'd0);
        check("len25_bd", 64'(bd_cnt), 64'(x0 + 1));

        // Zero length goes straight to DONE
        tick();
        out_len = 16'd0;
        do_reset();
        load(80);
        push_block(80);
        @(negedge clk);
        check("len0_busy", 64'(busy), 64'd1);
        check("len0_valid", 64'(out_valid), 64'd0);
        repeat (3) @(negedge clk);
        check("len0_none", 64'(sb.size()), 64'd0);
`endif

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/piso_squeeze.md
PISO_SQUEEZE -- requirements
Module: piso_squeeze

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 64, output word width in bits.
REQ-002 SHALL have parameter RATE, default 1344, block width in bits; RATE/DATA_SIZE = 21 words per block.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port hash_init  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port block_in  input  RATE  rate portion of permuted state.
REQ-006 SHALL have port load_en  input  1  one-cycle request to capture block_in.
REQ-007 SHALL have port out_len  input  16  total words to squeeze, sampled on first load after reset (SQUEEZE_LIMIT_EN only).
REQ-008 SHALL have port data_out  output  DATA_SIZE  current output word.
REQ-009 SHALL have port out_valid  output  1  data_out holds a valid word.
REQ-010 SHALL have port out_ready  input  1  downstream accepts word when high with out_valid.
REQ-011 SHALL have port out_last  output  1  qualifies final word of squeeze (SQUEEZE_LIMIT_EN only).
REQ-012 SHALL have port block_done  output  1  one-cycle pulse: block exhausted, next permutation required.
REQ-013 SHALL have port busy  output  1  high outside IDLE.

Function
REQ-014 SHALL implement states IDLE, SEND, DONE.
REQ-015 In IDLE, load_en SHALL capture block_in into the shift register, clear word counter to 0, enter SEND next cycle.
REQ-016 In SEND, out_valid SHALL be 1 and data_out SHALL equal shift register bits [DATA_SIZE-1:0] (word 0 = block_in[63:0], least-significant lane first).
REQ-017 A transfer SHALL occur on a rising edge with out_valid && out_ready; register shifts right by DATA_SIZE, counter increments.
REQ-018 With out_ready low, data_out and all state SHALL hold unchanged.
REQ-019 Transfer of word 20 SHALL return to IDLE and pulse block_done for exactly the following cycle.
REQ-020 load_en SHALL be ignored in SEND and DONE.
REQ-021 Counter SHALL be 5 bits, range 0..20, never wrap past 20.
REQ-022 out_valid SHALL be 0 in IDLE and DONE; data_out value SHALL be don't-care there.

Reset
REQ-023 hash_init high at a clock edge SHALL force IDLE, counter 0, shift register 0, remaining count 0, and out_valid, out_last, block_done, busy, data_out to 0, overriding any in-flight transfer or load.
REQ-024 After hash_init deasserts, first load_en SHALL be honoured the same edge.

Configuration
REQ-025 Macro SQUEEZE_LIMIT_EN SHALL enable output length limiting.
REQ-026 With it: remaining-words counter loads out_len on first load after reset, decrements per transfer; out_last = 1 on word where remaining == 1; that transfer enters DONE (no block_done pulse); DONE holds until hash_init; out_len == 0 SHALL enter DONE directly on load with no words emitted.
REQ-027 With it, block exhaustion with remaining > 0 SHALL behave per REQ-019.
REQ-028 Without it: out_len, out_last absent; blocks emitted indefinitely, DONE unreachable.

Structure
REQ-029 DATA_SIZE, RATE, WORDS_PER_BLOCK = 21 and state encoding typedef SHALL live in shared package keccak_pkg.
REQ-030 Single flat module; no sub-module.

Verification
REQ-031 Load block_in = {lane i = i+1}, out_ready constant 1 -> words 1..21 on consecutive cycles, block_done pulse one cycle after word 21.
REQ-032 out_ready toggling 1,0,0,1... -> data_out stable during stalls, sequence identical to REQ-031, no word lost/duplicated.
REQ-033 SQUEEZE_LIMIT_EN, out_len = 4 -> 4 words, out_last on 4th, DONE, busy stays 1, no block_done.
REQ-034 SQUEEZE_LIMIT_EN, out_len = 25 -> 21 words, block_done, second load, 4 words from new block, out_last on 25th overall.
REQ-035 hash_init asserted after word 7 -> next cycle IDLE, all outputs 0; new load restarts at word 0.
REQ-036 load_en pulsed during SEND at word 10 -> ignored, sequence continues unchanged.
